// File: rtl/text_cursor_ctrl.sv
// Write-side cursor controller for the 80x30 text buffer: glyph stream in, buffer writes out.
// Optional backspace support is compiled in with `define BACKSPACE_EN.
module text_cursor_ctrl #(
  parameter int         COLS     = 80,
  parameter int         ROWS     = 30,
  parameter logic [3:0] BLANK    = 4'h0,
  parameter logic [3:0] NL_CODE  = 4'hE,
  parameter logic [3:0] CLR_CODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  in_char,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  new_char,
  output logic [11:0] waddr,
  output logic        we,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

`ifdef BACKSPACE_EN
  localparam logic [3:0] BS_CODE = 4'hD;
  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL, BS_WR} state_t;
`else
  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;
`endif

  localparam logic [11:0] LAST_CELL = 12'(ROWS * COLS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [11:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [3:0]  nchar_q, nchar_d;

  logic [11:0] row_base, cur_addr;
  logic [4:0]  row_inc;

  assign row_base = 12'(row_q) * 12'(COLS);
  assign cur_addr = row_base + 12'(col_q);
  assign row_inc  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    nchar_d = nchar_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_char == CLR_CODE) begin
            row_d   = 5'd0;
            col_d   = 7'd0;
            cnt_d   = 12'd0;
            state_d = CLR_ALL;
          end else if (in_char == NL_CODE) begin
            row_d   = row_inc;
            col_d   = 7'd0;
            cnt_d   = 12'd0;
            state_d = CLR_ROW;
`ifdef BACKSPACE_EN
          end else if (in_char == BS_CODE) begin
            // Cursor steps back first; the blanking write happens in BS_WR.
            if (col_q != 7'd0) begin
              col_d = col_q - 7'd1;
            end else if (row_q != 5'd0) begin
              row_d = row_q - 5'd1;
              col_d = LAST_COL;
            end
            state_d = BS_WR;
`endif
          end else begin
            we_d    = 1'b1;
            waddr_d = cur_addr;
            nchar_d = in_char;
            if (col_q == LAST_COL) begin
              row_d   = row_inc;
              col_d   = 7'd0;
              cnt_d   = 12'd0;
              state_d = CLR_ROW;
            end else begin
              col_d = col_q + 7'd1;
            end
          end
        end
      end
      CLR_ROW: begin
        we_d    = 1'b1;
        waddr_d = row_base + cnt_q;
        nchar_d = BLANK;
        if (cnt_q == 12'(COLS - 1)) state_d = IDLE;
        else                        cnt_d   = cnt_q + 12'd1;
      end
      CLR_ALL: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        nchar_d = BLANK;
        if (cnt_q == LAST_CELL) state_d = IDLE;
        else                    cnt_d   = cnt_q + 12'd1;
      end
`ifdef BACKSPACE_EN
      BS_WR: begin
        we_d    = 1'b1;
        waddr_d = cur_addr;
        nchar_d = BLANK;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Reset lands in CLR_ALL so the buffer is always wiped from address 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLR_ALL;
      row_q   <= 5'd0;
      col_q   <= 7'd0;
      cnt_q   <= 12'd0;
      we_q    <= 1'b0;
      waddr_q <= 12'd0;
      nchar_q <= BLANK;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      nchar_q <= nchar_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == CLR_ROW) || (state_q == CLR_ALL);
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign new_char   = nchar_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Directed bench for text_cursor_ctrl: cursor model pushes expected writes, a monitor pops them.
module tb_text_cursor_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_char;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  new_char;
  logic [11:0] waddr;
  logic        we;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  int mrow = 0;
  int mcol = 0;

  always #5 clk = ~clk;

  text_cursor_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_char(in_char), .in_valid(in_valid),
    .in_ready(in_ready), .new_char(new_char), .waddr(waddr), .we(we),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", {20'd0, waddr}, 32'hFFFF);
      else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("write_addr", {20'd0, waddr}, {20'd0, e[15:4]});
        chk("write_data", {28'd0, new_char}, {28'd0, e[3:0]});
      end
    end
  end

  task automatic push_row_clear();
    for (int i = 0; i < 80; i++) exp_q.push_back({12'(mrow * 80 + i), 4'h0});
  endtask

  task automatic push_all_clear();
    for (int i = 0; i < 2400; i++) exp_q.push_back({12'(i), 4'h0});
  endtask

  task automatic model(input logic [3:0] c);
    if (c == 4'hF) begin
      mrow = 0; mcol = 0; push_all_clear();
    end else if (c == 4'hE) begin
      mcol = 0; mrow = (mrow == 29) ? 0 : mrow + 1; push_row_clear();
`ifdef BACKSPACE_EN
    end else if (c == 4'hD) begin
      if (mcol > 0) mcol--;
      else if (mrow > 0) begin mrow--; mcol = 79; end
      exp_q.push_back({12'(mrow * 80 + mcol), 4'h0});
`endif
    end else begin
      exp_q.push_back({12'(mrow * 80 + mcol), c});
      if (mcol == 79) begin
        mcol = 0; mrow = (mrow == 29) ? 0 : mrow + 1; push_row_clear();
      end else mcol++;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [3:0] c);
    int g = 0;
    while (in_ready !== 1'b1 && g < 5000) begin @(negedge clk); g++; end
    if (g >= 5000) chk("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_char  = c;
    model(c);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic count_busy(output int n, output int rdy);
    n = 0; rdy = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      if (in_ready !== 1'b0) rdy++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((in_ready !== 1'b1 || exp_q.size() != 0) && g < 5000) begin @(negedge clk); g++; end
    if (g >= 5000) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int n, rdy;
    rst_n = 1'b0; in_valid = 1'b0; in_char = 4'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_we", {31'd0, we}, 0);
    chk("rst_waddr", {20'd0, waddr}, 0);
    chk("rst_new_char", {28'd0, new_char}, 0);
    chk("rst_cursor", {20'd0, cursor_row, cursor_col}, 0);
    chk("rst_busy", {31'd0, busy}, 1);
    push_all_clear();
    rst_n = 1'b1;
    count_busy(n, rdy);
    chk("init_clear_busy_cycles", n, 2400);
    chk("init_clear_ready_low", rdy, 0);
    wait_idle();
    chk("init_cursor", {20'd0, cursor_row, cursor_col}, 0);
    chk("init_drained", exp_q.size(), 0);

    // back-to-back stream
    send(4'h1); send(4'h2); send(4'h3);
    chk("stream_col", {25'd0, cursor_col}, 3);
    chk("stream_row", {27'd0, cursor_row}, 0);
    wait_idle();

    // 80 chars from (5,0) then row wrap clear
    for (int i = 0; i < 5; i++) send(4'hE);
    wait_idle();
    chk("row5_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd5, 7'd0});
    for (int i = 0; i < 80; i++) send(4'((i % 13) + 1));
    chk("wrap_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd6, 7'd0});
    chk("wrap_ready_low", {31'd0, in_ready}, 0);
    count_busy(n, rdy);
    chk("wrap_busy_cycles", n, 80);
    chk("wrap_ready_during_clear", rdy, 0);
    wait_idle();

    // NL at (29,10) wraps to row 0
    for (int i = 0; i < 23; i++) send(4'hE);
    for (int i = 0; i < 10; i++) send(4'h7);
    wait_idle();
    chk("pre_nl_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd29, 7'd10});
    send(4'hE);
    chk("nl_wrap_cursor", {20'd0, cursor_row, cursor_col}, 0);
    chk("nl_busy", {31'd0, busy}, 1);
    wait_idle();

    // CLR at (3,7) aborted by reset on clear cycle 100
    for (int i = 0; i < 3; i++) send(4'hE);
    for (int i = 0; i < 7; i++) send(4'h9);
    wait_idle();
    chk("pre_clr_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd3, 7'd7});
    in_valid = 1'b1; in_char = 4'hF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("clr_cursor", {20'd0, cursor_row, cursor_col}, 0);
    for (int i = 0; i < 100; i++) exp_q.push_back({12'(i), 4'h0});
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_we", {31'd0, we}, 0);
    chk("abort_waddr", {20'd0, waddr}, 0);
    chk("abort_partial_drained", exp_q.size(), 0);
    mrow = 0; mcol = 0;
    push_all_clear();
    rst_n = 1'b1;
    count_busy(n, rdy);
    chk("restart_busy_cycles", n, 2400);
    wait_idle();
    chk("restart_cursor", {20'd0, cursor_row, cursor_col}, 0);

`ifdef BACKSPACE_EN
    send(4'hE); send(4'hE);
    wait_idle();
    send(4'hD);
    chk("bs_ready_low", {31'd0, in_ready}, 0);
    chk("bs_busy_low", {31'd0, busy}, 0);
    chk("bs_cursor", {20'd0, cursor_row, cursor_col}, {20'd0, 5'd1, 7'd79});
    wait_idle();
    send(4'hF);
    wait_idle();
    send(4'hD);
    wait_idle();
    chk("bs_origin_cursor", {20'd0, cursor_row, cursor_col}, 0);
`else
    send(4'hD);
    chk("d_printable_col", {25'd0, cursor_col}, 1);
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
